ram_dump_reader: RTL and testbench

Sequential reader for a single-port synchronous RAM with a 1-cycle read latency. On a start pulse it walks addresses 0..DEPTH-1 and presents each word on a valid/ready output stream, honouring backpressure. It sits between the detector's sample-storage RAM and the serial/readout path (e.g. the UART TX framer). It owns the RAM address and write ports for the whole dump.

---
 rtl/ram_dump_pkg.sv | 17 +
 rtl/ram_dump_reader.sv | 122 ++++++++++++
 tb/tb_ram_dump_reader.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_dump_pkg.sv
// Shared types and constants for the RAM dump reader.
// The state encoding is fixed at 2 bits so it can be probed and compared
// directly in simulation and on a logic analyser.
package ram_dump_pkg;

  // Dump sequencer states: idle, present address, capture read data, hold word downstream.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    PRESENT = 2'd3
  } state_e;

  // Value written back into the RAM when clear-on-read is compiled in.
  localparam int unsigned CLEAR_VALUE = 0;

endpackage : ram_dump_pkg

// File: rtl/ram_dump_reader.sv
// Sequential reader for a single-port synchronous RAM (1-cycle read latency).
// On start it walks addresses 0..DEPTH-1 and presents each word on a
// valid/ready stream. Each word takes ISSUE -> CAPTURE -> PRESENT, so peak
// throughput is one word every three cycles.
//
// Optional build macro: RAM_DUMP_CLEAR_EN
//   When defined, every word is cleared to CLEAR_VALUE in the CAPTURE cycle
//   (the RAM is read-before-write, so the old value is still captured).
//   When undefined, ram_write_en is constant 0 and the RAM is never modified.
module ram_dump_reader
  import ram_dump_pkg::*;
#(
  parameter  int SIZE  = 8,
  parameter  int DEPTH = 256,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic [AW-1:0]   ram_address,
  input  logic [SIZE-1:0] ram_read_data,
  output logic [SIZE-1:0] ram_write_data,
  output logic            ram_write_en,
  output logic [SIZE-1:0] out_data,
  output logic            out_valid,
  input  logic            out_ready
);

  // Termination is checked against the last index, so the address never
  // increments past DEPTH-1 and non-power-of-2 depths stop correctly.
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  state_e          state_q, state_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [SIZE-1:0] out_data_q, out_data_d;
  logic            out_valid_q, out_valid_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  // State register with synchronous reset; reset also kills any pending done.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // Next-state and datapath: start is only honoured in IDLE, the word is
  // held in PRESENT until the downstream handshake.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ISSUE;
          busy_d  = 1'b1;
          addr_d  = '0;
        end
      end
      ISSUE: begin
        // addr_q is on the RAM address bus this cycle.
        state_d = CAPTURE;
      end
      CAPTURE: begin
        // RAM output now reflects ram[addr_q].
        out_data_d  = ram_read_data;
        out_valid_d = 1'b1;
        state_d     = PRESENT;
      end
      PRESENT: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          if (addr_q == LAST_ADDR) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            addr_d  = '0;
          end else begin
            addr_d  = addr_q + AW'(1);
            state_d = ISSUE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign ram_address    = addr_q;
  assign ram_write_data = SIZE'(CLEAR_VALUE);
  assign out_data       = out_data_q;
  assign out_valid      = out_valid_q;
  assign busy           = busy_q;
  assign done           = done_q;

`ifdef RAM_DUMP_CLEAR_EN
  // Clear-on-read: write back in the cycle the old value is being captured.
  assign ram_write_en = (state_q == CAPTURE);
`else
  assign ram_write_en = 1'b0;
`endif

endmodule : ram_dump_reader

// File: tb/tb_ram_dump_reader.sv
// Self-checking bench for ram_dump_reader. Two instances share the clock:
// dut_a with DEPTH=8 and dut_b with DEPTH=5, each paired with a behavioural
// read-before-write RAM with a 1-cycle registered read. 'sel' chooses which
// instance the stimulus/observation muxes talk to.
module tb_ram_dump_reader;

  localparam int STALL_LEN = 10;
`ifdef RAM_DUMP_CLEAR_EN
  localparam bit CLEAR_EN = 1'b1;
`else
  localparam bit CLEAR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  logic start = 1'b0;
  logic ready = 1'b0;
  logic sel = 1'b0;
  int   load_mode = 0;

  int total = 0;
  int bad   = 0;

  // dut_a signals (DEPTH=8)
  logic       a_start, a_busy, a_done, a_we, a_valid, a_ready;
  logic [2:0] a_addr;
  logic [7:0] a_rd, a_wd, a_out;
  logic [7:0] a_mem [0:7];

  // dut_b signals (DEPTH=5, address still 3 bits)
  logic       b_start, b_busy, b_done, b_we, b_valid, b_ready;
  logic [2:0] b_addr;
  logic [7:0] b_rd, b_wd, b_out;
  logic [7:0] b_mem [0:7];

  // Observation mux
  logic       o_busy, o_done, o_we, o_valid;
  logic [2:0] o_addr;
  logic [7:0] o_wd, o_data;

  assign a_start = start & ~sel;
  assign b_start = start & sel;
  assign a_ready = ready;
  assign b_ready = ready;
  assign o_busy  = sel ? b_busy  : a_busy;
  assign o_done  = sel ? b_done  : a_done;
  assign o_we    = sel ? b_we    : a_we;
  assign o_valid = sel ? b_valid : a_valid;
  assign o_addr  = sel ? b_addr  : a_addr;
  assign o_wd    = sel ? b_wd    : a_wd;
  assign o_data  = sel ? b_out   : a_out;

  ram_dump_reader #(.SIZE(8), .DEPTH(8)) dut_a (
    .clk(clk), .rst(rst), .start(a_start), .busy(a_busy), .done(a_done),
    .ram_address(a_addr), .ram_read_data(a_rd), .ram_write_data(a_wd),
    .ram_write_en(a_we), .out_data(a_out), .out_valid(a_valid), .out_ready(a_ready)
  );

  ram_dump_reader #(.SIZE(8), .DEPTH(5)) dut_b (
    .clk(clk), .rst(rst), .start(b_start), .busy(b_busy), .done(b_done),
    .ram_address(b_addr), .ram_read_data(b_rd), .ram_write_data(b_wd),
    .ram_write_en(b_we), .out_data(b_out), .out_valid(b_valid), .out_ready(b_ready)
  );

  // Behavioural RAMs: registered read of the old value, then optional write.
  // load_mode: 1 = a[i]=i^A5, 2 = a[i]=FF, 3 = b[i]=10+i (sentinel EE above 4)
  always @(posedge clk) begin
    a_rd <= a_mem[a_addr];
    if (a_we) a_mem[a_addr] <= a_wd;
    b_rd <= b_mem[b_addr];
    if (b_we) b_mem[b_addr] <= b_wd;
    if (load_mode == 1) begin
      for (int i = 0; i < 8; i++) a_mem[i] <= 8'(i) ^ 8'hA5;
    end else if (load_mode == 2) begin
      for (int i = 0; i < 8; i++) a_mem[i] <= 8'hFF;
    end else if (load_mode == 3) begin
      for (int i = 0; i < 8; i++) b_mem[i] <= (i < 5) ? 8'h10 + 8'(i) : 8'hEE;
    end
  end

  // Results of the most recent dump
  logic [7:0] got[$];
  int         got_cycle[$];
  int         ndone, done_cyc, busy_fall_cyc, stall_seen, we_cnt, max_addr;
  bit         stall_bad, we_bad, timed_out, rebusy;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int m);
    load_mode = m;
    step();
    load_mode = 0;
  endtask

  // Drives one dump on the selected DUT and records what the stream delivered.
  // Cycle numbers count edges since the start edge (sampled on the negedge).
  task automatic run_dump(input bit rand_ready, input int stall_word,
                          input logic [7:0] stall_exp, input int start_word,
                          input int budget);
    bit prev_busy, st_sent, forced_low;
    got.delete();
    got_cycle.delete();
    ndone = 0; done_cyc = -1; busy_fall_cyc = -1; stall_seen = 0;
    we_cnt = 0; max_addr = 0; stall_bad = 0; we_bad = 0; timed_out = 1;
    rebusy = 0; st_sent = 0; forced_low = 0;
    start = 1'b1;
    ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    step();
    start = 1'b0;
    prev_busy = 1'b1;
    for (int c = 1; c <= budget; c++) begin
      @(negedge clk);
      if (o_done) begin
        ndone++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (prev_busy && !o_busy && busy_fall_cyc < 0) busy_fall_cyc = c;
      if (!prev_busy && o_busy) rebusy = 1;
      prev_busy = o_busy;
      if (int'(o_addr) > max_addr) max_addr = int'(o_addr);
      if (o_we) begin
        we_cnt++;
        if (o_wd !== 8'h00) we_bad = 1;
      end
      if (forced_low && o_valid) begin
        stall_seen++;
        if (o_data !== stall_exp || o_addr !== 3'(stall_word)) stall_bad = 1;
      end
      if (o_valid && ready) begin
        got.push_back(o_data);
        got_cycle.push_back(c);
        $display("word %0d data=%02h cycle=%0d", got.size() - 1, o_data, c);
      end
      if (done_cyc >= 0 && c >= done_cyc + 3) begin
        timed_out = 0;
        break;
      end
      step();
      start = (start_word >= 0 && !st_sent && got.size() == start_word && o_busy);
      if (start) st_sent = 1;
      forced_low = (stall_word >= 0 && got.size() == stall_word && stall_seen < STALL_LEN);
      if (forced_low) ready = 1'b0;
      else if (rand_ready) ready = 1'($urandom_range(0, 1));
      else ready = 1'b1;
    end
    start = 1'b0;
    ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; ready = 1'b0; sel = 1'b0;
    repeat (2) step();
    rst = 1'b0;
    @(negedge clk);
    total++; if (a_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b want=0", a_busy); end
    total++; if (a_done !== 1'b0) begin bad++; $display("FAIL reset_done got=%0b want=0", a_done); end
    total++; if (a_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b want=0", a_valid); end
    total++; if (a_out !== 8'h00) begin bad++; $display("FAIL reset_data got=%02h want=00", a_out); end
    total++; if (a_addr !== 3'd0) begin bad++; $display("FAIL reset_addr got=%0d want=0", a_addr); end
    total++; if (a_we !== 1'b0) begin bad++; $display("FAIL reset_we got=%0b want=0", a_we); end
    total++; if (b_busy !== 1'b0 || b_valid !== 1'b0 || b_addr !== 3'd0) begin
      bad++; $display("FAIL reset_b got busy=%0b valid=%0b addr=%0d want 0/0/0", b_busy, b_valid, b_addr);
    end
    step();
  endtask

  task automatic test_basic();
    sel = 1'b0;
    load(1);
    run_dump(1'b0, -1, 8'h00, -1, 200);
    total++; if (timed_out) begin bad++; $display("FAIL basic_timeout got=no_done want=done"); end
    total++; if (got.size() != 8) begin bad++; $display("FAIL basic_count got=%0d want=8", got.size()); end
    for (int k = 0; k < got.size() && k < 8; k++) begin
      total++;
      if (got[k] !== (8'(k) ^ 8'hA5)) begin bad++; $display("FAIL basic_word%0d got=%02h want=%02h", k, got[k], 8'(k) ^ 8'hA5); end
      total++;
      if (got_cycle[k] != 3 + 3 * k) begin bad++; $display("FAIL basic_cycle%0d got=%0d want=%0d", k, got_cycle[k], 3 + 3 * k); end
    end
    total++; if (ndone != 1) begin bad++; $display("FAIL basic_done_pulses got=%0d want=1", ndone); end
    total++; if (done_cyc != 25) begin bad++; $display("FAIL basic_done_cycle got=%0d want=25", done_cyc); end
    total++; if (busy_fall_cyc != done_cyc) begin bad++; $display("FAIL basic_busy_fall got=%0d want=%0d", busy_fall_cyc, done_cyc); end
    total++; if (max_addr != 7) begin bad++; $display("FAIL basic_max_addr got=%0d want=7", max_addr); end
  endtask

  task automatic test_backpressure();
    sel = 1'b0;
    load(1);
    run_dump(1'b1, 3, 8'h03 ^ 8'hA5, -1, 800);
    total++; if (timed_out) begin bad++; $display("FAIL bp_timeout got=no_done want=done"); end
    total++; if (got.size() != 8) begin bad++; $display("FAIL bp_count got=%0d want=8", got.size()); end
    for (int k = 0; k < got.size() && k < 8; k++) begin
      total++;
      if (got[k] !== (8'(k) ^ 8'hA5)) begin bad++; $display("FAIL bp_word%0d got=%02h want=%02h", k, got[k], 8'(k) ^ 8'hA5); end
    end
    total++; if (stall_seen != STALL_LEN) begin bad++; $display("FAIL bp_stall_len got=%0d want=%0d", stall_seen, STALL_LEN); end
    total++; if (stall_bad) begin bad++; $display("FAIL bp_stall_hold got=changed want=A6_at_addr3"); end
    total++; if (ndone != 1) begin bad++; $display("FAIL bp_done_pulses got=%0d want=1", ndone); end
  endtask

  task automatic test_start_while_busy();
    sel = 1'b0;
    load(1);
    run_dump(1'b0, -1, 8'h00, 2, 200);
    total++; if (got.size() != 8) begin bad++; $display("FAIL swb_count got=%0d want=8", got.size()); end
    total++; if (got.size() > 7 && got[7] !== 8'hA2) begin bad++; $display("FAIL swb_last got=%02h want=A2", got[7]); end
    total++; if (ndone != 1) begin bad++; $display("FAIL swb_done_pulses got=%0d want=1", ndone); end
    total++; if (rebusy) begin bad++; $display("FAIL swb_restart got=busy_again want=idle"); end
  endtask

  task automatic test_reset_mid();
    int  nw;
    bit  hit, done_seen;
    sel = 1'b0;
    load(1);
    start = 1'b1; ready = 1'b1;
    step();
    start = 1'b0;
    nw = 0; hit = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (nw == 4 && a_valid && !ready) begin hit = 1; break; end
      if (a_valid && ready) nw++;
      step();
      ready = (nw < 4);
    end
    total++; if (!hit) begin bad++; $display("FAIL rmid_reach got=no_word4 want=word4"); end
    total++; if (a_out !== 8'hA1) begin bad++; $display("FAIL rmid_word4 got=%02h want=A1", a_out); end
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    total++; if (a_valid !== 1'b0) begin bad++; $display("FAIL rmid_valid got=%0b want=0", a_valid); end
    total++; if (a_busy !== 1'b0) begin bad++; $display("FAIL rmid_busy got=%0b want=0", a_busy); end
    total++; if (a_addr !== 3'd0) begin bad++; $display("FAIL rmid_addr got=%0d want=0", a_addr); end
    total++; if (a_out !== 8'h00) begin bad++; $display("FAIL rmid_data got=%02h want=00", a_out); end
    done_seen = a_done;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (a_done) done_seen = 1;
    end
    total++; if (done_seen) begin bad++; $display("FAIL rmid_done got=1 want=0"); end
    step();
    load(1);
    run_dump(1'b0, -1, 8'h00, -1, 200);
    total++; if (got.size() != 8) begin bad++; $display("FAIL rmid_replay_count got=%0d want=8", got.size()); end
    total++; if (got.size() > 0 && got[0] !== 8'hA5) begin bad++; $display("FAIL rmid_replay_first got=%02h want=A5", got[0]); end
  endtask

  task automatic test_depth5();
    sel = 1'b1;
    load(3);
    run_dump(1'b0, -1, 8'h00, -1, 200);
    total++; if (timed_out) begin bad++; $display("FAIL d5_timeout got=no_done want=done"); end
    total++; if (got.size() != 5) begin bad++; $display("FAIL d5_count got=%0d want=5", got.size()); end
    for (int k = 0; k < got.size() && k < 5; k++) begin
      total++;
      if (got[k] !== 8'h10 + 8'(k)) begin bad++; $display("FAIL d5_word%0d got=%02h want=%02h", k, got[k], 8'h10 + 8'(k)); end
    end
    total++; if (max_addr != 4) begin bad++; $display("FAIL d5_max_addr got=%0d want=4", max_addr); end
    total++; if (ndone != 1 || done_cyc != 16) begin bad++; $display("FAIL d5_done got=%0d@%0d want=1@16", ndone, done_cyc); end
    sel = 1'b0;
  endtask

  task automatic test_clear();
    logic [7:0] exp_after;
    exp_after = CLEAR_EN ? 8'h00 : 8'hFF;
    sel = 1'b0;
    load(2);
    run_dump(1'b0, -1, 8'h00, -1, 200);
    total++; if (got.size() != 8) begin bad++; $display("FAIL clr_count got=%0d want=8", got.size()); end
    for (int k = 0; k < got.size() && k < 8; k++) begin
      total++;
      if (got[k] !== 8'hFF) begin bad++; $display("FAIL clr_word%0d got=%02h want=FF", k, got[k]); end
    end
    total++; if (we_cnt != (CLEAR_EN ? 8 : 0)) begin bad++; $display("FAIL clr_we_count got=%0d want=%0d", we_cnt, CLEAR_EN ? 8 : 0); end
    total++; if (we_bad) begin bad++; $display("FAIL clr_wdata got=nonzero want=00"); end
    for (int i = 0; i < 8; i++) begin
      total++;
      if (a_mem[i] !== exp_after) begin bad++; $display("FAIL clr_mem%0d got=%02h want=%02h", i, a_mem[i], exp_after); end
    end
    run_dump(1'b0, -1, 8'h00, -1, 200);
    total++; if (got.size() != 8) begin bad++; $display("FAIL clr2_count got=%0d want=8", got.size()); end
    for (int k = 0; k < got.size() && k < 8; k++) begin
      total++;
      if (got[k] !== exp_after) begin bad++; $display("FAIL clr2_word%0d got=%02h want=%02h", k, got[k], exp_after); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_start_while_busy();
    test_reset_mid();
    test_depth5();
    test_clear();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_ram_dump_reader
